// File: rtl/multi_tree_feeder.sv
// multi_tree_feeder
//   Deserializes a serial AXI-stream of fixed-point samples (one frame per
//   product) into a NUM-lane parallel vector for the multiplier tree.
//   Short frames are padded with PAD_VALUE (multiplicative identity); frames
//   longer than NUM are truncated, the excess discarded, and a sticky
//   overflow flag raised.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast/tready
//                       serial sample input (tready held high after reset)
//   dout                parallel vector, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   dout_tvalid         per-lane valid, all bits pulse together for one cycle
//   frame_cnt           number of emitted frames (wrapping)
//   overflow            sticky truncation flag
//   clr_overflow        synchronous clear of overflow (a same-cycle set wins)
module multi_tree_feeder #(
  parameter int                    NUM        = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = 16'h0010
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [NUM*DATA_WIDTH-1:0] dout,
  output logic [NUM-1:0]            dout_tvalid,
  output logic [15:0]               frame_cnt,
  output logic                      overflow,
  input  logic                      clr_overflow
);

  localparam int CW = $clog2(NUM) + 1;

  typedef enum logic {FILL, DROP} state_t;

  state_t                    state, state_nx;
  logic [CW-1:0]             cnt;
  logic [NUM*DATA_WIDTH-1:0] fill_buf;
  logic [NUM*DATA_WIDTH-1:0] merged;
  logic                      accept;
  logic                      last_lane;
  logic                      emit;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign last_lane = (cnt == CW'(NUM - 1));
  assign emit      = accept && (state == FILL) && (s_axis_tlast || last_lane);

  // Completed vector: lanes already filled, the current sample at lane cnt,
  // identity in every lane above it.
  always_comb begin
    merged = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (k == 32'(cnt))
        merged[k*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
      else if (k > 32'(cnt))
        merged[k*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
      else
        merged[k*DATA_WIDTH +: DATA_WIDTH] = fill_buf[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL: if (accept && last_lane && !s_axis_tlast) state_nx = DROP;
      DROP: if (accept && s_axis_tlast)               state_nx = FILL;
      default:                                        state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_tready <= 1'b0;
      cnt           <= '0;
      fill_buf      <= '0;
      dout          <= '0;
      dout_tvalid   <= '0;
      frame_cnt     <= '0;
      overflow      <= 1'b0;
    end else begin
      // Ready rises on the first edge after reset release and stays high.
      s_axis_tready <= 1'b1;
      dout_tvalid   <= '0;

      if (accept && state == FILL) begin
        fill_buf[32'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata;
        if (emit) begin
          dout        <= merged;
          dout_tvalid <= '1;
          frame_cnt   <= frame_cnt + 16'd1;
          cnt         <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      if (accept && state == DROP) overflow <= 1'b1;
      else if (clr_overflow)       overflow <= 1'b0;
    end
  end

endmodule

// File: doc/multi_tree_feeder.md
Name: multi_tree_feeder

Overview:
- Front-end deserializer for the fixed-point multiplier tree.
- Collects a serial AXI-stream of fixed-point samples, one frame per product, into a NUM-lane parallel vector.
- Presents the vector with per-lane valids in the format the tree consumes: din packed lane-major, din_tvalid one bit per lane.
- Short frames are padded with the multiplicative identity. Long frames are truncated and flagged.

Parameters:
- NUM, 8: number of lanes per frame, ≥2.
- DATA_WIDTH, 16: sample width in bits.
- PAD_VALUE, 16'h0010: identity value in input fixed-point format, written to unfilled lanes. Width DATA_WIDTH.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_tdata  input  DATA_WIDTH  serial sample.
- s_axis_tvalid  input  1  sample valid.
- s_axis_tlast  input  1  last sample of frame.
- s_axis_tready  output  1  sample accepted when tvalid&&tready.
- dout  output  NUM*DATA_WIDTH  parallel vector; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- dout_tvalid  output  NUM  per-lane valid; all bits pulse together.
- frame_cnt  output  16  emitted frames, wraps at 65535→0.
- overflow  output  1  sticky: frame exceeded NUM samples.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n low) sets these values:
  - all outputs to 0: s_axis_tready, dout, dout_tvalid, frame_cnt, overflow;
  - internal lane counter to 0;
  - state to FILL;
  - fill buffer to 0.
- s_axis_tready stays 0 during reset and for the first clk edge after rst_n deasserts. It is then held at 1. There is no backpressure, because the tree has no ready.
- Reset mid-frame discards the partial frame. No emission occurs.
- Internal storage:
  - fill buffer: NUM×DATA_WIDTH;
  - output register dout, separate from the fill buffer;
  - lane counter cnt, width $clog2(NUM)+1.
- State FILL:
  - An accepted sample is written to buffer lane cnt, and cnt increments.
  - Emit condition: the accepted sample has tlast=1, or cnt==NUM-1.
  - On emit:
    - dout ← buffer with the current sample merged in;
    - lanes with index > the current sample's index ← PAD_VALUE;
    - cnt ← 0.
  - After emit, the next state is as follows:
    - FILL if tlast=1;
    - DROP if cnt==NUM-1 and tlast=0.
- State DROP:
  - Accepted samples are discarded. Each one sets overflow.
  - An accepted sample with tlast=1 returns the block to FILL. It causes no emission.
- Emission timing:
  - dout_tvalid = all-ones for exactly one cycle, in the cycle after the completing sample is accepted (latency 1).
  - frame_cnt increments in the same cycle dout_tvalid is high.
  - Otherwise dout_tvalid = 0.
- dout holds its value between emissions. It is stable while dout_tvalid is low.
- Back-to-back frames at full rate are legal: a sample for frame n+1 can be accepted in the same cycle frame n is emitted, with no bubble.
- Cycles with s_axis_tvalid=0 hold all state. Gaps inside a frame are legal.
- overflow is set by any discard in DROP and cleared by clr_overflow. If set and clear occur in the same cycle, set wins.
- A frame of exactly NUM samples with tlast on the last sample emits and returns to FILL. It does not set overflow.
- A 1-sample frame emits lane 0 = sample and lanes 1..NUM-1 = PAD_VALUE.

Test Plan:
(NUM=8, DATA_WIDTH=16, PAD_VALUE=0x0010)
1. Reset, then 8 samples 0x0001..0x0008 at one per cycle, tlast on the 8th → one cycle after the 8th: dout_tvalid=8'hFF, dout lanes 0..7 = 1..8, frame_cnt=1, overflow=0.
2. 3-sample frame 0x0A,0x0B,0x0C with tlast on the third → dout lanes 0..2 = 0A,0B,0C; lanes 3..7 = 0x0010; single pulse.
3. 10-sample frame 1..10 with tlast on the 10th → emit after the 8th sample with lanes 1..8; overflow=1 after the 9th; no second emit; the next frame fills from lane 0. Then pulse clr_overflow → overflow=0.
4. Two 8-sample frames back-to-back, tvalid continuous → two pulses exactly 8 cycles apart; frame 2 data correct; dout stable between the pulses.
5. Random tvalid gaps inside a 5-sample frame → same dout as without gaps; dout_tvalid pulses once, one cycle after the tlast beat.
6. rst_n asserted after 4 samples of a frame; release; then a 2-sample frame → only lanes 0..1 = new data, rest 0x0010; frame_cnt=1; tready low through reset plus one cycle.
